serial_to_parallel_lanes: RTL and testbench

Parametrised deserializer that assembles `lanes`-bit serial beats into `width`-bit words and queues completed words in an output FIFO. It sits between a narrow serial source and a word-oriented consumer. It adds several features: selectable bit order, multi-bit beats, ready/valid backpressure on both sides, and a flush for abandoning partial words.

---
 rtl/serial_to_parallel_lanes.sv | 115 +++++++++++
 tb/tb_serial_to_parallel_lanes.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_lanes.sv
// rtl/serial_to_parallel_lanes.sv - deserializer assembling lanes-bit beats into width-bit words behind an output FIFO
module serial_to_parallel_lanes #(
   parameter int width     = 8,
   parameter int lanes     = 1,
   parameter int depth     = 4,
   parameter int msb_first = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         serial_valid,
   input  logic [lanes-1:0]             serial_data,
   output logic                         serial_ready,
   input  logic                         flush,
   output logic                         parallel_valid,
   input  logic                         parallel_ready,
   output logic [width-1:0]             parallel_data,
   output logic [$clog2(depth+1)-1:0]   level
);

   localparam int BEATS = width / lanes;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ACC_W = (BEATS > 1) ? (width - lanes) : 1;
   localparam int AW    = $clog2(depth);
   localparam int LW    = $clog2(depth + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
   localparam logic [LW-1:0]    FULL_LVL = LW'(depth);

   logic [CNT_W-1:0] r_cnt;
   logic [ACC_W-1:0] r_acc;
   logic             r_ready_en;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic [width-1:0] r_last;
   logic [width-1:0] r_mem [depth];

   logic             w_full;
   logic             w_empty;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic [width-1:0] w_word;
   logic [ACC_W-1:0] w_acc_next;

   // The accumulator is a shift register of the beats seen so far; the
   // shift direction places beat 0 at the low or high end of the final word.
   generate
      if (BEATS == 1) begin : g_single
         assign w_word     = serial_data;
         assign w_acc_next = r_acc;
      end else if (msb_first != 0) begin : g_msb
         assign w_word     = {r_acc, serial_data};
         assign w_acc_next = w_word[width-lanes-1:0];
      end else begin : g_lsb
         assign w_word     = {serial_data, r_acc};
         assign w_acc_next = w_word[width-1:lanes];
      end
   endgenerate

   assign w_full         = (r_level == FULL_LVL);
   assign w_empty        = (r_level == '0);
   assign serial_ready   = r_ready_en && !w_full;
   assign w_accept       = serial_valid && serial_ready && !flush;
   assign w_push         = w_accept && (r_cnt == LAST_CNT);
   assign parallel_valid = !w_empty;
   assign w_pop          = parallel_valid && parallel_ready;
   assign parallel_data  = w_empty ? r_last : r_mem[r_rd_ptr];
   assign level          = r_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_acc      <= '0;
         r_ready_en <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_last     <= '0;
      end else begin
         r_ready_en <= 1'b1;
         if (flush) begin
            r_cnt <= '0;
            r_acc <= '0;
         end else if (w_accept) begin
            if (w_push) begin
               r_cnt <= '0;
               r_acc <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
               r_acc <= w_acc_next;
            end
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         // Empty FIFO keeps presenting the most recently consumed word.
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_last   <= r_mem[r_rd_ptr];
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + LW'(1);
         end else if (w_pop && !w_push) begin
            r_level <= r_level - LW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_word;
      end
   end

endmodule

// File: tb/tb_serial_to_parallel_lanes.sv
// tb/tb_serial_to_parallel_lanes.sv - three-configuration bench with a queue-style reference model
module tb_serial_to_parallel_lanes;

   logic       clk;
   logic       rst_n;
   logic       sv [3];
   logic       fl [3];
   logic       pr [3];
   logic [1:0] sd [3];
   logic       w_sr [3];
   logic       w_pv [3];
   logic [7:0] w_pd [3];
   logic [2:0] w_lv [3];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: beats of the current word and the word queue.
   int         lanes_of [3];
   bit         msb_of   [3];
   logic [1:0] m_beats  [3][8];
   int         m_nb     [3];
   logic [7:0] m_fifo   [3][4];
   int         m_cnt    [3];
   logic [7:0] m_last   [3];
   bit         m_started;

   serial_to_parallel_lanes #(.width(8), .lanes(1), .depth(4), .msb_first(0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .serial_valid(sv[0]), .serial_data(sd[0][0]),
      .serial_ready(w_sr[0]), .flush(fl[0]), .parallel_valid(w_pv[0]),
      .parallel_ready(pr[0]), .parallel_data(w_pd[0]), .level(w_lv[0]));

   serial_to_parallel_lanes #(.width(8), .lanes(1), .depth(4), .msb_first(1)) u_msb (
      .clk(clk), .rst_n(rst_n), .serial_valid(sv[1]), .serial_data(sd[1][0]),
      .serial_ready(w_sr[1]), .flush(fl[1]), .parallel_valid(w_pv[1]),
      .parallel_ready(pr[1]), .parallel_data(w_pd[1]), .level(w_lv[1]));

   serial_to_parallel_lanes #(.width(8), .lanes(2), .depth(4), .msb_first(0)) u_l2 (
      .clk(clk), .rst_n(rst_n), .serial_valid(sv[2]), .serial_data(sd[2]),
      .serial_ready(w_sr[2]), .flush(fl[2]), .parallel_valid(w_pv[2]),
      .parallel_ready(pr[2]), .parallel_data(w_pd[2]), .level(w_lv[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask

   function automatic bit exp_ready(input int d);
      return m_started && (m_cnt[d] < 4);
   endfunction

   function automatic logic [7:0] assemble(input int d);
      logic [7:0] word = 8'h00;
      int nbeats = 8 / lanes_of[d];
      for (int k = 0; k < nbeats; k++) begin
         logic [7:0] b = 8'(m_beats[d][k]);
         if (msb_of[d]) word = word | (b << (8 - (k + 1) * lanes_of[d]));
         else           word = word | (b << (k * lanes_of[d]));
      end
      return word;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_nb[d]   = 0;
         m_cnt[d]  = 0;
         m_last[d] = 8'h00;
      end
      m_started = 1'b0;
   endtask

   task automatic model_edge();
      if (!rst_n) return;
      for (int d = 0; d < 3; d++) begin
         bit         rdy  = exp_ready(d);
         bit         pop  = (m_cnt[d] > 0) && pr[d];
         bit         push = 1'b0;
         logic [7:0] word = 8'h00;
         if (fl[d]) begin
            m_nb[d] = 0;
         end else if (sv[d] && rdy) begin
            m_beats[d][m_nb[d]] = (lanes_of[d] == 1) ? {1'b0, sd[d][0]} : sd[d];
            m_nb[d]++;
            if (m_nb[d] == 8 / lanes_of[d]) begin
               word    = assemble(d);
               push    = 1'b1;
               m_nb[d] = 0;
            end
         end
         if (pop) begin
            m_last[d] = m_fifo[d][0];
            for (int i = 0; i < 3; i++) m_fifo[d][i] = m_fifo[d][i+1];
            m_cnt[d]--;
         end
         if (push) begin
            m_fifo[d][m_cnt[d]] = word;
            m_cnt[d]++;
         end
      end
      m_started = 1'b1;
   endtask

   task automatic settle_check();
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("serial_ready", d, 32'(w_sr[d]), 32'(exp_ready(d)));
         chk("parallel_valid", d, 32'(w_pv[d]), 32'(m_cnt[d] > 0));
         chk("parallel_data", d, 32'(w_pd[d]), 32'((m_cnt[d] > 0) ? m_fifo[d][0] : m_last[d]));
         chk("level", d, 32'(w_lv[d]), 32'(m_cnt[d]));
      end
   endtask

   task automatic edge_step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step();
      settle_check();
      edge_step();
   endtask

   task automatic idle_all();
      for (int d = 0; d < 3; d++) begin
         sv[d] = 1'b0; fl[d] = 1'b0; pr[d] = 1'b0; sd[d] = 2'b00;
      end
   endtask

   task automatic drain_all();
      idle_all();
      for (int d = 0; d < 3; d++) pr[d] = 1'b1;
      for (int i = 0; i < 6; i++) step();
      idle_all();
   endtask

   task automatic feed_byte0(input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         sv[0] = 1'b1;
         sd[0] = {1'b0, b[i]};
         step();
      end
      sv[0] = 1'b0;
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] bytes [5];
      logic [7:0] cur;
      logic [1:0] l2 [4];
      int idx;
      int n_pop;
      bit acc;

      lanes_of[0] = 1; lanes_of[1] = 1; lanes_of[2] = 2;
      msb_of[0]   = 0; msb_of[1]   = 1; msb_of[2]   = 0;
      model_reset();
      idle_all();
      rst_n = 1'b0;
      @(negedge clk);
      step();
      chk("reset_data", 0, 32'(w_pd[0]), 32'h0);
      rst_n = 1'b1;
      step();
      step();

      // Directed words on all three configurations.
      pat = 8'b0100_1101;
      l2[0] = 2'b01; l2[1] = 2'b10; l2[2] = 2'b11; l2[3] = 2'b00;
      for (int i = 0; i < 8; i++) begin
         sv[0] = 1'b1; sd[0] = {1'b0, pat[i]};
         sv[1] = 1'b1; sd[1] = {1'b0, pat[i]};
         sv[2] = (i < 4); sd[2] = (i < 4) ? l2[i] : 2'b00;
         step();
      end
      idle_all();
      #1;
      chk("lsb_word", 0, 32'(w_pd[0]), 32'h4D);
      chk("msb_word", 1, 32'(w_pd[1]), 32'hB2);
      chk("lanes2_word", 2, 32'(w_pd[2]), 32'h39);
      chk("lsb_level", 0, 32'(w_lv[0]), 32'd1);
      step();
      drain_all();

      // Same beats with random valid gaps.
      idx = 0;
      for (int c = 0; c < 200 && idx < 8; c++) begin
         sv[0] = 1'($urandom_range(0, 1)); sv[1] = sv[0];
         sd[0] = {1'b0, pat[idx]};         sd[1] = sd[0];
         acc = sv[0] && exp_ready(0);
         step();
         if (acc) idx++;
      end
      idle_all();
      chk("gap_beats_done", 0, 32'(idx), 32'd8);
      #1;
      chk("gap_msb_word", 1, 32'(w_pd[1]), 32'hB2);
      chk("gap_lsb_word", 0, 32'(w_pd[0]), 32'h4D);
      step();
      drain_all();

      // Backpressure: five words into a four-deep FIFO.
      for (int w = 0; w < 5; w++) bytes[w] = 8'($urandom);
      idx = 0;
      for (int c = 0; c < 60; c++) begin
         cur = bytes[(idx < 40) ? idx / 8 : 0];
         sv[0] = (idx < 40); sd[0] = {1'b0, cur[idx % 8]};
         sv[1] = sv[0];      sd[1] = sd[0];
         acc = sv[0] && exp_ready(0);
         step();
         if (acc) idx++;
      end
      chk("bp_stalled_at", 0, 32'(idx), 32'd32);
      #1;
      chk("bp_level_full", 0, 32'(w_lv[0]), 32'd4);
      chk("bp_ready_low", 0, 32'(w_sr[0]), 32'd0);
      @(negedge clk);
      pr[0] = 1'b1; pr[1] = 1'b1;
      n_pop = 0;
      for (int c = 0; c < 100 && (idx < 40 || m_cnt[0] > 0); c++) begin
         cur = bytes[(idx < 40) ? idx / 8 : 0];
         sv[0] = (idx < 40); sd[0] = {1'b0, cur[idx % 8]};
         sv[1] = sv[0];      sd[1] = sd[0];
         acc = sv[0] && exp_ready(0);
         settle_check();
         if (w_pv[0] && n_pop < 5) begin
            chk("bp_order", 0, 32'(w_pd[0]), 32'(bytes[n_pop]));
            n_pop++;
         end
         edge_step();
         if (acc) idx++;
      end
      chk("bp_words_popped", 0, 32'(n_pop), 32'd5);
      drain_all();

      // Flush drops the partial word and the beat offered alongside it.
      for (int i = 0; i < 3; i++) begin
         sv[0] = 1'b1; sd[0] = {1'b0, 1'($urandom_range(0, 1))};
         step();
      end
      fl[0] = 1'b1; sv[0] = 1'b1; sd[0] = 2'b01;
      step();
      fl[0] = 1'b0;
      feed_byte0(8'hA5);
      #1;
      chk("flush_word", 0, 32'(w_pd[0]), 32'hA5);
      chk("flush_level", 0, 32'(w_lv[0]), 32'd1);
      step();
      drain_all();

      // Random traffic on all configurations.
      for (int c = 0; c < 300; c++) begin
         for (int d = 0; d < 3; d++) begin
            sv[d] = 1'($urandom_range(0, 1));
            sd[d] = 2'($urandom_range(0, 3));
            pr[d] = 1'($urandom_range(0, 3) != 0);
            fl[d] = ($urandom_range(0, 15) == 0);
         end
         step();
      end
      drain_all();

      // Asynchronous reset mid-word with two words queued.
      feed_byte0(8'h11);
      feed_byte0(8'h22);
      for (int i = 0; i < 3; i++) begin
         sv[0] = 1'b1; sd[0] = 2'b01;
         step();
      end
      idle_all();
      #1;
      chk("pre_reset_level", 0, 32'(w_lv[0]), 32'd2);
      #1;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("async_ready", d, 32'(w_sr[d]), 32'd0);
         chk("async_valid", d, 32'(w_pv[d]), 32'd0);
         chk("async_data", d, 32'(w_pd[d]), 32'd0);
         chk("async_level", d, 32'(w_lv[d]), 32'd0);
      end
      model_reset();
      @(negedge clk);
      step();
      rst_n = 1'b1;
      step();
      feed_byte0(8'h3C);
      #1;
      chk("post_reset_word", 0, 32'(w_pd[0]), 32'h3C);
      chk("post_reset_level", 0, 32'(w_lv[0]), 32'd1);
      step();
      pr[0] = 1'b1;
      step();
      pr[0] = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("post_reset_empty", 0, 32'(w_lv[0]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
